// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between N packet requesters, the arbiter and one fifo write port.
// The master side sources requests and the fifo full flag. The slave side is the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 32
);
  logic [NUM_REQUESTERS-1:0]            req_valid;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]            req_last;
  logic [NUM_REQUESTERS-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]                data_in;
  logic                                 data_in_valid;
  logic                                 data_in_full;
  logic [NUM_REQUESTERS-1:0]            grant;
  logic                                 busy;

  modport master (
    output req_valid, req_data, req_last, data_in_full,
    input  req_ready, data_in, data_in_valid, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, data_in_full,
    output req_ready, data_in, data_in_valid, grant, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter that merges N requesters onto one fifo write port.
// A grant lasts until the owner's last beat or MAX_BURST beats, and is followed by one idle cycle.
module fifo_write_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 8
) (
  input  logic                 clock_in,
  input  logic                 rst_in_n,
  fifo_write_arbiter_if.slave  bus
);
  localparam int OW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQUESTERS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [OW-1:0]   owner_reg, owner_next;
  logic [OW-1:0]   last_owner_reg, last_owner_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next, beat_cnt_inc;
  logic [OW-1:0]   winner, cand;
  logic            found;
  logic            any_req, owner_valid, owner_last, transfer, active;
  logic [DATA_WIDTH-1:0] word [NUM_REQUESTERS];

  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_word
      assign word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign any_req      = |bus.req_valid;
  assign owner_valid  = bus.req_valid[owner_reg];
  assign owner_last   = bus.req_last[owner_reg];
  assign transfer     = (state_reg == BURST) && owner_valid && !bus.data_in_full;
  assign beat_cnt_inc = beat_cnt_reg + CW'(1);

  // Walk upward from the requester after last_owner, wrapping at NUM_REQUESTERS-1.
  always_comb begin
    winner = last_owner_reg;
    cand   = last_owner_reg;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + OW'(1);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!rst_in_n) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= LAST_IDX;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = BURST;
          owner_next    = winner;
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        if (transfer) begin
          beat_cnt_next = beat_cnt_inc;
          if (owner_last || (beat_cnt_inc == CNT_MAX)) begin
            state_next      = IDLE;
            last_owner_next = owner_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so a burst in flight reads as idle immediately.
  assign active = (state_reg == BURST) && rst_in_n;

  always_comb begin
    bus.busy          = active;
    bus.grant         = '0;
    bus.req_ready     = '0;
    bus.data_in_valid = 1'b0;
    bus.data_in       = word[owner_reg];
    if (active) begin
      bus.grant[owner_reg]     = 1'b1;
      bus.req_ready[owner_reg] = !bus.data_in_full;
      bus.data_in_valid        = owner_valid;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a vector table, hand-written multi-cycle sequences, and random traffic.
// The random traffic is checked against a packet-level reference model and a fifo scoreboard.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  logic rst_a_n, rst_b_n;

  fifo_write_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) bus_a ();
  fifo_write_arbiter_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) bus_b ();

  fifo_write_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut_a (
    .clock_in (clock_in),
    .rst_in_n (rst_a_n),
    .bus      (bus_a.slave)
  );

  fifo_write_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
    .clock_in (clock_in),
    .rst_in_n (rst_b_n),
    .bus      (bus_b.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: the owner index (-1 means no grant), beats taken, and the previous owner.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = N - 1;
  int n_writes = 0;
  logic [DW-1:0] q_exp[$];
  logic [DW-1:0] q_got[$];

  function automatic bit bit_of(input logic [N-1:0] v, input int idx);
    return ((v >> idx) & N'(1)) != '0;
  endfunction

  function automatic int rr_pick(input int after, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(v, (after + k) % N)) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic apply_a(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic f, input logic [N*DW-1:0] d);
    rst_a_n            = r;
    bus_a.req_valid    = v;
    bus_a.req_last     = l;
    bus_a.data_in_full = f;
    bus_a.req_data     = d;
  endtask

  // Capture the fifo write seen on the port, take the clock edge, then advance the model.
  task automatic edge_a();
    logic [DW-1:0] w;
    if (bus_a.data_in_valid && !bus_a.data_in_full) q_got.push_back(bus_a.data_in);
    @(posedge clock_in);
    if (!rst_a_n) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      if (bus_a.req_valid != '0) begin
        m_owner = rr_pick(m_last, bus_a.req_valid);
        m_cnt   = 0;
      end
    end else if (bit_of(bus_a.req_valid, m_owner) && !bus_a.data_in_full) begin
      w = DW'(bus_a.req_data >> (m_owner * DW));
      q_exp.push_back(w);
      n_writes++;
      m_cnt++;
      $display("write %0d: requester %0d beat %0d data %08h", n_writes, m_owner, m_cnt, w);
      if (bit_of(bus_a.req_last, m_owner) || m_cnt == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic          act;
    logic [N-1:0]  eg, er;
    logic          edv;
    act = rst_a_n && (m_owner >= 0);
    eg  = act ? N'(1) << m_owner : '0;
    edv = act && bit_of(bus_a.req_valid, m_owner);
    er  = (act && !bus_a.data_in_full) ? eg : '0;
    chk({tag, "_busy"},  64'(bus_a.busy),          64'(act));
    chk({tag, "_grant"}, 64'(bus_a.grant),         64'(eg));
    chk({tag, "_dv"},    64'(bus_a.data_in_valid), 64'(edv));
    chk({tag, "_ready"}, 64'(bus_a.req_ready),     64'(er));
    if (edv) chk({tag, "_data"}, 64'(bus_a.data_in), 64'(DW'(bus_a.req_data >> (m_owner * DW))));
  endtask

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic          full;
    logic [N-1:0]  grant;
    logic          dv;
    logic [N-1:0]  ready;
    logic          busy;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [N*DW-1:0] fixed_data;
    logic [N*DW-1:0] d;
    logic [N-1:0]    v, l;
    logic            f;
    int beats, full_left;
    bit full_done;

    fixed_data = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    //           rst  valid    last     full  grant    dv    ready    busy  data
    tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'h101};
    tbl[4]  = '{1'b1, 4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1, 32'h101};
    tbl[5]  = '{1'b1, 4'b0110, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'h101};
    tbl[6]  = '{1'b1, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 32'h102};
    tbl[8]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'h102};
    tbl[9]  = '{1'b1, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'h103};
    tbl[11] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 4'b1001, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h100};
    tbl[14] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0};

    rst_b_n = 1'b0;
    bus_b.req_valid = '0;
    bus_b.req_last = '0;
    bus_b.data_in_full = 1'b0;
    bus_b.req_data = '0;
    apply_a(1'b0, '0, '0, 1'b0, fixed_data);
    @(posedge clock_in);
    #1;

    for (int i = 0; i < 15; i++) begin
      apply_a(tbl[i].rst_n, tbl[i].valid, tbl[i].last, tbl[i].full, fixed_data);
      #4;
      $display("vector %0d: grant %b dv %b ready %b busy %b", i,
               bus_a.grant, bus_a.data_in_valid, bus_a.req_ready, bus_a.busy);
      chk($sformatf("vec%0d_grant", i), 64'(bus_a.grant),         64'(tbl[i].grant));
      chk($sformatf("vec%0d_dv", i),    64'(bus_a.data_in_valid), 64'(tbl[i].dv));
      chk($sformatf("vec%0d_ready", i), 64'(bus_a.req_ready),     64'(tbl[i].ready));
      chk($sformatf("vec%0d_busy", i),  64'(bus_a.busy),          64'(tbl[i].busy));
      if (tbl[i].dv) chk($sformatf("vec%0d_data", i), 64'(bus_a.data_in), 64'(tbl[i].data));
      edge_a();
    end

    // Requester 2 streams without a last beat, stalls on a full fifo for 5 cycles,
    // and must be cut off after MAX_BURST beats while requester 1 waits.
    d = fixed_data;
    apply_a(1'b1, 4'b0100, '0, 1'b0, d);
    #4;
    chk("s2_idle_before", 64'(bus_a.grant), 64'(0));
    edge_a();
    beats = 0;
    full_left = 0;
    full_done = 0;
    for (int c = 0; c < 40; c++) begin
      f = 1'b0;
      if (beats == 3 && !full_done) begin
        full_left = 5;
        full_done = 1;
      end
      if (full_left > 0) begin
        f = 1'b1;
        full_left--;
      end
      d = {32'h0000_0103, 32'h0000_2000 + 32'(beats), 32'h0000_1111, 32'h0000_0100};
      apply_a(1'b1, 4'b0110, '0, f, d);
      #4;
      if (bus_a.grant != 4'b0100) break;
      if (f) begin
        chk("s3_ready_frozen", 64'(bus_a.req_ready), 64'(0));
        chk("s3_data_stable", 64'(bus_a.data_in), 64'(32'h0000_2000 + 32'(beats)));
      end
      if (bus_a.data_in_valid && !f) beats++;
      edge_a();
    end
    chk("s2_beats", 64'(beats), 64'(MB));
    chk("s2_idle_gap", 64'(bus_a.grant), 64'(0));
    edge_a();
    apply_a(1'b1, 4'b0110, '0, 1'b0, d);
    #4;
    chk("s2_next_owner", 64'(bus_a.grant), 64'(4'b0010));
    edge_a();

    // Random traffic against the reference model.
    for (int c = 0; c < 500; c++) begin
      v = N'($urandom);
      l = N'($urandom & $urandom);
      f = ($urandom_range(0, 3) == 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      apply_a(($urandom_range(0, 99) != 0), v, l, f, d);
      #4;
      check_model("rnd");
      edge_a();
    end

    // MAX_BURST=1: a continuously valid requester 3 gets one beat every other cycle.
    bus_b.req_valid = 4'b1000;
    bus_b.req_data  = fixed_data;
    rst_b_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #4;
      $display("mb1 cycle %0d: dv %b grant %b", k, bus_b.data_in_valid, bus_b.grant);
      chk($sformatf("s6_dv%0d", k),   64'(bus_b.data_in_valid), 64'(k % 2));
      chk($sformatf("s6_busy%0d", k), 64'(bus_b.busy),          64'(k % 2));
      if (k % 2 == 1) chk($sformatf("s6_grant%0d", k), 64'(bus_b.grant), 64'(4'b1000));
      @(posedge clock_in);
      #1;
    end

    chk("sb_count", 64'(q_got.size()), 64'(q_exp.size()));
    for (int i = 0; i < q_got.size() && i < q_exp.size(); i++) begin
      if (q_got[i] !== q_exp[i]) chk($sformatf("sb_word%0d", i), 64'(q_got[i]), 64'(q_exp[i]));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4: number of write requesters; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: word width, equal to the downstream fifo DATA_WIDTH.
REQ-003 Parameter MAX_BURST, default 8: maximum beats per grant; legal range 1..256.
REQ-004 clock_in  input  1  single clock; all logic on its rising edge.
REQ-005 rst_in_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  NUM_REQUESTERS  per-requester word-valid.
REQ-007 req_data  input  NUM_REQUESTERS*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQUESTERS  per-requester end-of-packet marker, qualified by req_valid.
REQ-009 req_ready  output  NUM_REQUESTERS  per-requester accept.
REQ-010 data_in  output  DATA_WIDTH  word to fifo write port.
REQ-011 data_in_valid  output  1  write strobe to fifo.
REQ-012 data_in_full  input  1  fifo full flag.
REQ-013 grant  output  NUM_REQUESTERS  one-hot current owner; all-zero when idle.
REQ-014 busy  output  1  high while state is BURST.

Function
REQ-015 The block shall implement two states, IDLE and BURST.
REQ-016 In IDLE, data_in_valid and req_ready shall be 0 and grant shall be all-zero.
REQ-017 In IDLE, with any req_valid bit high, the block shall, on the next edge, enter BURST, set grant to the round-robin winner, and clear the beat counter.
REQ-018 The round-robin winner shall be the first requester with req_valid high, searching upward from (last_owner+1) modulo NUM_REQUESTERS.
REQ-019 Arbitration latency shall be exactly one cycle from req_valid high in IDLE to grant high.
REQ-020 In BURST, data_in shall equal the owner's req_data slice and data_in_valid shall equal the owner's req_valid, both combinationally.
REQ-021 In BURST, req_ready[owner] shall equal !data_in_full; all other req_ready bits shall be 0.
REQ-022 A beat transfers on an edge where data_in_valid=1 and data_in_full=0; the beat counter shall then increment by one.
REQ-023 The beat counter shall be clog2(MAX_BURST+1) bits wide and shall never exceed MAX_BURST.
REQ-024 The grant shall end on a transfer with req_last[owner]=1, or on the transfer that brings the counter to MAX_BURST, whichever is first.
REQ-025 When the grant ends, the block shall enter IDLE on that edge and record the owner as last_owner.
REQ-026 Exactly one idle cycle shall occur between consecutive grants.
REQ-027 In BURST, if the owner drops req_valid without a last beat, the grant shall be held with no transfer and no counter change.
REQ-028 In BURST, a request arriving from a non-owner shall not affect the grant; it shall be considered at the next IDLE.
REQ-029 If data_in_full=1 while data_in_valid=1, no transfer shall occur and outputs shall hold; the owner keeps its word stable until transfer.
REQ-030 A last beat on the MAX_BURST-th transfer shall end the grant once; there shall be no double counting.
REQ-031 At most one data_in_valid beat per cycle; never data_in_valid=1 while data_in_full=1 and a transfer is counted.

Reset
REQ-032 With rst_in_n=0 at a rising edge, the block shall set state to IDLE, grant to 0, the beat counter to 0, and last_owner to NUM_REQUESTERS-1, so requester 0 has first priority.
REQ-033 Reset asserted during BURST shall abandon the burst without completing it; data_in_valid and req_ready shall be 0 from the following cycle.
REQ-034 busy, grant, req_ready and data_in_valid shall read 0 while in reset.

Verification
REQ-035 Scenario 1, after reset: req_valid=4'b1111 held, each requester sends 2-beat packets, full=0 -> grants 0,1,2,3,0 in order; each grant is 2 beats; one idle cycle between grants.
REQ-036 Scenario 2: requester 2 streams with req_last never asserted, MAX_BURST=8 -> grant released after exactly 8 transfers; with requester 1 waiting, grant passes to 1 (not 2) after the idle cycle.
REQ-037 Scenario 3: data_in_full=1 for 5 cycles mid-burst -> req_ready[owner]=0, counter frozen, and data_in stable; on resume, no beat is lost or duplicated (fifo contents match the sent sequence).
REQ-038 Scenario 4: owner drops req_valid for 3 cycles mid-packet while requester 3 is requesting -> grant stays with the owner, zero transfers, and the packet completes before requester 3 is granted.
REQ-039 Scenario 5: rst_in_n=0 for one cycle at beat 4 of a burst by requester 1 -> next cycle state=IDLE and grant=0; the next arbitration with all requesting grants requester 0.
REQ-040 Scenario 6: MAX_BURST=1, single requester 3 continuously valid -> alternating BURST and IDLE cycles with one transfer per grant, i.e. data_in_valid high every other cycle.
